// File: rtl/alarm_sounder.sv
// Alarm sounder: rings on alarm/time match, with stop, 60 s timeout and optional snooze.
// Optional feature: define SNOOZE_EN to include the SNOOZE state and 540 s snooze counter.
module alarm_sounder (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       SEC_TICK,
  input  logic       ALARM_EN,
  input  logic [3:0] ALARM_HRS,
  input  logic [5:0] ALARM_MINS,
  input  logic       ALARM_AM_PM,
  input  logic [3:0] TIME_HRS,
  input  logic [5:0] TIME_MINS,
  input  logic       TIME_AM_PM,
  input  logic       STOP_BTN,
  input  logic       SNOOZE_BTN,
  output logic       RINGING,
  output logic       SNOOZING,
  output logic       SPEAKER
);

`ifdef SNOOZE_EN
  typedef enum logic [1:0] {IDLE, RING, DONE, SNOOZE} state_t;
`else
  typedef enum logic [1:0] {IDLE, RING, DONE} state_t;
`endif

  state_t     state, state_n;
  logic [5:0] ring_cnt;
  logic       beep_ph;
  logic       stop_q;
  logic       match;
  logic       stop_press;
  logic       ring_entry;

  assign match = ALARM_EN &&
                 ({TIME_AM_PM, TIME_HRS, TIME_MINS} == {ALARM_AM_PM, ALARM_HRS, ALARM_MINS});
  assign stop_press = STOP_BTN & ~stop_q;
  assign ring_entry = (state_n == RING) && (state != RING);

`ifdef SNOOZE_EN
  logic [9:0] snz_cnt;
  logic       snz_q;
  logic       snz_press;
  assign snz_press = SNOOZE_BTN & ~snz_q;
`else
  logic unused_snooze_btn;
  assign unused_snooze_btn = SNOOZE_BTN;
`endif

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (match) state_n = RING;
      RING: begin
        if (stop_press)                           state_n = DONE;
`ifdef SNOOZE_EN
        else if (snz_press)                       state_n = SNOOZE;
`endif
        else if (SEC_TICK && ring_cnt == 6'd59)   state_n = DONE;
      end
`ifdef SNOOZE_EN
      SNOOZE: begin
        if (stop_press)                           state_n = DONE;
        else if (SEC_TICK && snz_cnt == 10'd0)    state_n = RING;
      end
`endif
      DONE: if (!match) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // Disarming overrides every other transition
    if (!ALARM_EN) state_n = IDLE;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state    <= IDLE;
      ring_cnt <= 6'd0;
      beep_ph  <= 1'b0;
      stop_q   <= 1'b0;
    end else begin
      state  <= state_n;
      stop_q <= STOP_BTN;
      if (ring_entry) begin
        ring_cnt <= 6'd0;
        beep_ph  <= 1'b1;
      end else if (state == RING && state_n == RING && SEC_TICK) begin
        ring_cnt <= ring_cnt + 6'd1;
        beep_ph  <= ~beep_ph;
      end
    end
  end

`ifdef SNOOZE_EN
  // Snooze countdown: 539 down to 0, then the tick at 0 re-rings (540 s)
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      snz_cnt <= 10'd0;
      snz_q   <= 1'b0;
    end else begin
      snz_q <= SNOOZE_BTN;
      if (state_n == SNOOZE && state != SNOOZE)
        snz_cnt <= 10'd539;
      else if (state == SNOOZE && SEC_TICK && snz_cnt != 10'd0)
        snz_cnt <= snz_cnt - 10'd1;
    end
  end
  assign SNOOZING = (state == SNOOZE);
`else
  assign SNOOZING = 1'b0;
`endif

  assign RINGING = (state == RING);
  assign SPEAKER = (state == RING) && beep_ph;

endmodule
